fifo_rd_packer: RTL

//  Read-side consumer for the async FIFO: lives in the rclk domain, pops the FIFO read port
//  (rdata/rempty/rinc) and packs RATIO consecutive DSIZE words into one wide beat.

---
 rtl/fifo_rd_packer.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs RATIO show-ahead FIFO words into one wide
// valid/ready beat, with flush to force out a partially filled beat.
module fifo_rd_packer #(
  parameter  int DSIZE = 8,
  parameter  int RATIO = 4,
  localparam int CW    = $clog2(RATIO + 1)
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*RATIO-1:0] m_data,
  output logic [CW-1:0]          m_count,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy
);

  localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);

  logic [DSIZE-1:0]       acc_q [RATIO];
  logic [DSIZE-1:0]       acc_d [RATIO];
  logic [CW-1:0]          acc_cnt_q, acc_cnt_d;
  logic [DSIZE*RATIO-1:0] m_data_q, m_data_d;
  logic [CW-1:0]          m_count_q, m_count_d;
  logic                   m_valid_q, m_valid_d;
  logic                   flush_pend_q, flush_pend_d;

  logic out_free;
  logic acc_full;
  logic acc_some;
  logic xfer;

  assign out_free = !m_valid_q | m_ready;
  assign acc_full = (acc_cnt_q == CNT_FULL);
  assign acc_some = (acc_cnt_q != '0);
  assign xfer     = out_free & (acc_full | (flush_pend_q & acc_some));
  // Pop may coincide with a transfer: the freed accumulator takes the word in lane 0.
  assign rinc     = !rrst & !rempty & !flush_pend_q & (!acc_full | xfer);

  always_comb begin
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    m_data_d     = m_data_q;
    m_count_d    = m_count_q;
    m_valid_d    = m_valid_q;
    flush_pend_d = flush_pend_q;

    if (xfer) begin
      for (int i = 0; i < RATIO; i++) begin
        m_data_d[i*DSIZE +: DSIZE] = (CW'(i) < acc_cnt_q) ? acc_q[i] : '0;
      end
      m_count_d = acc_cnt_q;
      m_valid_d = 1'b1;
      if (rinc) begin
        acc_d[0]  = rdata;
        acc_cnt_d = CW'(1);
      end else begin
        acc_cnt_d = '0;
      end
    end else begin
      if (rinc) begin
        for (int i = 0; i < RATIO; i++) begin
          if (acc_cnt_q == CW'(i)) acc_d[i] = rdata;
        end
        acc_cnt_d = acc_cnt_q + CW'(1);
      end
      if (m_valid_q & m_ready) m_valid_d = 1'b0;
    end

    // On a full-beat transfer the post-edge count decides whether flush has anything to emit.
    if (flush_pend_q) begin
      if (xfer) flush_pend_d = 1'b0;
    end else if (flush) begin
      flush_pend_d = xfer ? (acc_cnt_d != '0) : acc_some;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc_q        <= '{default: '0};
      acc_cnt_q    <= '0;
      m_data_q     <= '0;
      m_count_q    <= '0;
      m_valid_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      m_data_q     <= m_data_d;
      m_count_q    <= m_count_d;
      m_valid_q    <= m_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_count = m_count_q;
  assign m_valid = m_valid_q;
  assign busy    = acc_some | m_valid_q | flush_pend_q;

endmodule
